step_tracker: RTL and testbench

STEP_TRACKER -- requirements
Module: step_tracker

---
 rtl/fitbit_pkg.sv | 38 +++
 rtl/one_sec_timer.sv | 35 +++
 rtl/step_tracker.sv | 146 ++++++++++++++
 tb/tb_step_tracker.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fitbit_pkg.sv
// ============================================================================
// Module   : fitbit_pkg
// Purpose  : Shared widths, saturation limits and activity-state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fitbit_pkg;

    localparam int STEP_W  = 14;
    localparam int TOTAL_W = 20;
    localparam int DIST_W  = 6;
    localparam int SPS_W   = 8;
    localparam int HACT_W  = 12;

    localparam logic [STEP_W-1:0] STEP_SAT = 14'd9999;
    localparam logic [DIST_W-1:0] DIST_MAX = 6'd63;
    localparam logic [HACT_W-1:0] HACT_MAX = 12'd4095;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIGH = 2'd2
    } state_t;

    // Saturating accumulate for the high-activity seconds total.
    function automatic logic [HACT_W-1:0] hact_add(
        input logic [HACT_W-1:0] acc,
        input logic [HACT_W-1:0] inc
    );
        logic [HACT_W:0] sum;
        sum = {1'b0, acc} + {1'b0, inc};
        return sum[HACT_W] ? HACT_MAX : sum[HACT_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/one_sec_timer.sv
// ============================================================================
// Module   : one_sec_timer
// Purpose  : One-cycle TICK every CLK_HZ cycles; first on edge CLK_HZ after reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module one_sec_timer #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic CLK,
    input  logic RESET,
    output logic TICK
);

    localparam int                c_cnt_w = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLK_HZ - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign TICK = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/step_tracker.sv
// ============================================================================
// Module   : step_tracker
// Purpose  : Step counting, distance, per-second rate and high-activity time.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_tracker
    import fitbit_pkg::*;
#(
    parameter int CLK_HZ              = 100_000_000,
    parameter int STEPS_PER_HALF_MILE = 1024,
    parameter int HIGH_RATE           = 64,
    parameter int HIGH_MIN_SEC        = 60
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              PULSE,
    output logic [STEP_W-1:0] STEP_COUNT,
    output logic              SAT,
    output logic [DIST_W-1:0] DISTANCE,
    output logic [SPS_W-1:0]  STEPS_PER_SEC,
    output logic [HACT_W-1:0] HIGH_ACT_SEC
);

    localparam int                 c_run_w      = $clog2(HIGH_MIN_SEC + 1);
    localparam logic [c_run_w-1:0] c_run_target = c_run_w'(HIGH_MIN_SEC);
    localparam logic [HACT_W-1:0]  c_min_inc    = HACT_W'(HIGH_MIN_SEC);
    localparam logic [TOTAL_W-1:0] c_total_max  = '1;

    logic                r_p_q;
    logic                r_p_qq;
    logic                r_step;
    logic [TOTAL_W-1:0]  r_total;
    logic [SPS_W-1:0]    r_window;
    logic [c_run_w-1:0]  r_run;
    state_t              r_state;

    logic                w_tick;
    logic                w_high;
    logic [c_run_w-1:0]  w_run_next;
    logic [TOTAL_W-1:0]  w_dist_q;

    one_sec_timer #(
        .CLK_HZ (CLK_HZ)
    ) u_timer (
        .CLK   (CLK),
        .RESET (RESET),
        .TICK  (w_tick)
    );

    assign w_high     = (r_window >= SPS_W'(HIGH_RATE));
    assign w_run_next = r_run + c_run_w'(1);
    assign w_dist_q   = r_total / TOTAL_W'(STEPS_PER_HALF_MILE);

    // Two-stage sampling then a registered rising-edge strobe.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_p_q  <= 1'b0;
            r_p_qq <= 1'b0;
            r_step <= 1'b0;
        end else begin
            r_p_q  <= PULSE;
            r_p_qq <= r_p_q;
            r_step <= r_p_q & ~r_p_qq;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_total    <= '0;
            STEP_COUNT <= '0;
            SAT        <= 1'b0;
            DISTANCE   <= '0;
        end else begin
            if (r_step && (r_total != c_total_max)) begin
                r_total <= r_total + TOTAL_W'(1);
            end
            STEP_COUNT <= (r_total > TOTAL_W'(STEP_SAT)) ? STEP_SAT : r_total[STEP_W-1:0];
            SAT        <= (r_total > TOTAL_W'(STEP_SAT));
            DISTANCE   <= (w_dist_q > TOTAL_W'(DIST_MAX)) ? DIST_MAX : w_dist_q[DIST_W-1:0];
        end
    end

    // A strobe landing on the tick opens the new window rather than closing the old one.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_window      <= '0;
            STEPS_PER_SEC <= '0;
        end else if (w_tick) begin
            STEPS_PER_SEC <= r_window;
            r_window      <= {{(SPS_W-1){1'b0}}, r_step};
        end else if (r_step && (r_window != '1)) begin
            r_window <= r_window + SPS_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= IDLE;
            r_run        <= '0;
            HIGH_ACT_SEC <= '0;
        end else if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (w_high) begin
                        r_run <= c_run_w'(1);
                        if (c_run_target == c_run_w'(1)) begin
                            r_state      <= HIGH;
                            HIGH_ACT_SEC <= hact_add(HIGH_ACT_SEC, c_min_inc);
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_high) begin
                        r_run <= w_run_next;
                        if (w_run_next == c_run_target) begin
                            r_state      <= HIGH;
                            HIGH_ACT_SEC <= hact_add(HIGH_ACT_SEC, c_min_inc);
                        end
                    end else begin
                        r_state <= IDLE;
                        r_run   <= '0;
                    end
                end
                HIGH: begin
                    if (w_high) begin
                        HIGH_ACT_SEC <= hact_add(HIGH_ACT_SEC, HACT_W'(1));
                    end else begin
                        r_state <= IDLE;
                        r_run   <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_run   <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_step_tracker.sv
// ============================================================================
// Module   : tb_step_tracker
// Purpose  : Randomised and directed checks of step_tracker against a
//            cycle-level behavioural model of steps, windows and activity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_step_tracker;

    // The window must be long enough to hold 70 alternating pulses.
    localparam int CLK_HZ       = 200;
    localparam int SPHM         = 1024;
    localparam int HIGH_RATE    = 64;
    localparam int HIGH_MIN_SEC = 3;

    logic        CLK   = 1'b0;
    logic        RESET = 1'b1;
    logic        PULSE = 1'b0;
    logic [13:0] STEP_COUNT;
    logic        SAT;
    logic [5:0]  DISTANCE;
    logic [7:0]  STEPS_PER_SEC;
    logic [11:0] HIGH_ACT_SEC;

    int n_cmp = 0;
    int n_bad = 0;

    step_tracker #(
        .CLK_HZ              (CLK_HZ),
        .STEPS_PER_HALF_MILE (SPHM),
        .HIGH_RATE           (HIGH_RATE),
        .HIGH_MIN_SEC        (HIGH_MIN_SEC)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .PULSE         (PULSE),
        .STEP_COUNT    (STEP_COUNT),
        .SAT           (SAT),
        .DISTANCE      (DISTANCE),
        .STEPS_PER_SEC (STEPS_PER_SEC),
        .HIGH_ACT_SEC  (HIGH_ACT_SEC)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model state: steps are tracked by the edge index at which they become visible.
    int  edge_cnt = 0;
    bit  prev_s   = 1'b0;
    bit  step_now;
    int  m_total  = 0;
    int  m_win    = 0;
    int  m_sps    = 0;
    int  m_hact   = 0;
    int  m_streak = 0;
    int  due_tot[$];
    int  due_win[$];

    always begin
        @(posedge CLK);
        if (RESET) begin
            edge_cnt = 0;
            prev_s   = 1'b0;
            m_total  = 0;
            m_win    = 0;
            m_sps    = 0;
            m_hact   = 0;
            m_streak = 0;
            due_tot.delete();
            due_win.delete();
        end else begin
            edge_cnt++;
            if (PULSE && !prev_s) begin
                due_tot.push_back(edge_cnt + 3);
                due_win.push_back(edge_cnt + 2);
            end
            prev_s = PULSE;
            if (due_tot.size() != 0 && due_tot[0] == edge_cnt) begin
                void'(due_tot.pop_front());
                if (m_total < 1048575) m_total++;
            end
            step_now = (due_win.size() != 0 && due_win[0] == edge_cnt);
            if (step_now) void'(due_win.pop_front());
            if (edge_cnt % CLK_HZ == 0) begin
                m_sps = (m_win > 255) ? 255 : m_win;
                if (m_sps >= HIGH_RATE) begin
                    m_streak++;
                    if (m_streak == HIGH_MIN_SEC) m_hact += HIGH_MIN_SEC;
                    else if (m_streak > HIGH_MIN_SEC) m_hact += 1;
                    if (m_hact > 4095) m_hact = 4095;
                end else begin
                    m_streak = 0;
                end
                m_win = step_now ? 1 : 0;
            end else if (step_now) begin
                m_win++;
            end
        end
        #1;
        if (!RESET) begin
            check("step_count", STEP_COUNT, (m_total > 9999) ? 9999 : m_total);
            check("sat", SAT, (m_total > 9999) ? 1 : 0);
            check("distance", DISTANCE, (m_total / SPHM > 63) ? 63 : m_total / SPHM);
            check("steps_per_sec", STEPS_PER_SEC, m_sps);
            check("high_act_sec", HIGH_ACT_SEC, m_hact);
        end
    end

    task automatic wait_edge(input int target);
        int guard = 0;
        while (edge_cnt < target) begin
            @(negedge CLK);
            guard++;
            if (guard > 50000) begin
                n_bad++;
                $display("FAIL wait_edge: edge %0d never reached %0d", edge_cnt, target);
                break;
            end
        end
        if (edge_cnt > target) begin
            n_bad++;
            $display("FAIL wait_edge: edge %0d already past %0d", edge_cnt, target);
        end
    endtask

    task automatic do_reset(input logic pulse_at_release);
        @(negedge CLK);
        RESET = 1'b1;
        PULSE = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_step_count", STEP_COUNT, 0);
        check("rst_sat", SAT, 0);
        check("rst_distance", DISTANCE, 0);
        check("rst_sps", STEPS_PER_SEC, 0);
        check("rst_hact", HIGH_ACT_SEC, 0);
        PULSE = pulse_at_release;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic pulse(input int hi, input int lo);
        PULSE = 1'b1;
        repeat (hi) @(negedge CLK);
        PULSE = 1'b0;
        repeat (lo) @(negedge CLK);
    endtask

    // n alternating steps inside window k, then stop just after the closing tick.
    task automatic fill_window(input int k, input int n);
        wait_edge(CLK_HZ * (k - 1));
        repeat (n) pulse(1, 1);
        wait_edge(CLK_HZ * k);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w4[6] = '{64, 64, 64, 64, 63, 64};
        int h4[6] = '{0, 0, 3, 4, 4, 4};
        int w5[6] = '{64, 64, 10, 64, 64, 64};
        int h5[6] = '{0, 0, 0, 0, 0, 3};

        // Latency, pulse width independence, held pulse.
        do_reset(1'b0);
        wait_edge(10);
        PULSE = 1'b1;
        repeat (3) @(negedge CLK);
        check("latency_early", STEP_COUNT, 0);
        PULSE = 1'b0;
        @(negedge CLK);
        check("latency_first", STEP_COUNT, 1);
        repeat (6) @(negedge CLK);
        repeat (4) pulse(3, 7);
        repeat (4) @(negedge CLK);
        check("five_pulses", STEP_COUNT, 5);
        PULSE = 1'b1;
        repeat (50) @(negedge CLK);
        check("held_high", STEP_COUNT, 6);
        PULSE = 1'b0;
        repeat (5) @(negedge CLK);
        check("held_released", STEP_COUNT, 6);

        // Saturation and distance.
        do_reset(1'b0);
        repeat (9999) pulse($urandom_range(1, 2), 1);
        repeat (4) @(negedge CLK);
        check("sc_at_9999", STEP_COUNT, 9999);
        check("sat_at_9999", SAT, 0);
        check("dist_at_9999", DISTANCE, 9);
        pulse(1, 1);
        repeat (4) @(negedge CLK);
        check("sc_at_10000", STEP_COUNT, 9999);
        check("sat_at_10000", SAT, 1);
        repeat (50) pulse($urandom_range(1, 2), 1);
        repeat (4) @(negedge CLK);
        check("sc_at_10050", STEP_COUNT, 9999);
        check("dist_at_10050", DISTANCE, 9);

        // Step strobe coinciding with the tick.
        do_reset(1'b0);
        repeat (70) pulse(1, 1);
        wait_edge(CLK_HZ - 3);
        pulse(1, 1);
        wait_edge(CLK_HZ);
        check("sps_70", STEPS_PER_SEC, 70);
        wait_edge(2 * CLK_HZ);
        check("sps_tick_step", STEPS_PER_SEC, 1);

        // Run into high activity and back out.
        do_reset(1'b0);
        for (int k = 0; k < 6; k++) begin
            fill_window(k + 1, w4[k]);
            check("w4_sps", STEPS_PER_SEC, w4[k]);
            check("w4_hact", HIGH_ACT_SEC, h4[k]);
        end

        // Broken run restarts the count.
        do_reset(1'b0);
        for (int k = 0; k < 6; k++) begin
            fill_window(k + 1, w5[k]);
            check("w5_hact", HIGH_ACT_SEC, h5[k]);
        end

        // Asynchronous reset mid-window, then pulse held through release.
        do_reset(1'b0);
        repeat (37) pulse(1, 2);
        repeat (4) @(negedge CLK);
        check("pre_rst_count", STEP_COUNT, 37);
        #2;
        RESET = 1'b1;
        #1;
        check("async_step_count", STEP_COUNT, 0);
        check("async_sat", SAT, 0);
        check("async_distance", DISTANCE, 0);
        check("async_sps", STEPS_PER_SEC, 0);
        check("async_hact", HIGH_ACT_SEC, 0);
        @(negedge CLK);
        PULSE = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        repeat (10) @(negedge CLK);
        PULSE = 1'b0;
        wait_edge(CLK_HZ - 1);
        check("first_tick_early", STEPS_PER_SEC, 0);
        wait_edge(CLK_HZ);
        check("first_tick", STEPS_PER_SEC, 1);
        check("release_step", STEP_COUNT, 1);

        // Randomised windows of mixed density, one random reset in the middle.
        do_reset(1'($urandom_range(0, 1)));
        for (int w = 0; w < 24; w++) begin
            int mode;
            if (w == 12) do_reset(1'($urandom_range(0, 1)));
            mode = $urandom_range(0, 3);
            for (int c = 0; c < CLK_HZ; c++) begin
                case (mode)
                    0:       PULSE = ~PULSE;
                    1:       PULSE = 1'($urandom_range(0, 1));
                    2:       if ($urandom_range(0, 7) == 0) PULSE = ~PULSE;
                    default: if ($urandom_range(0, 4) != 0) PULSE = ~PULSE;
                endcase
                @(negedge CLK);
            end
        end
        PULSE = 1'b0;
        repeat (5) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
